// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the processor mode sequencer.
package proc_ctrl_pkg;

  localparam int unsigned MODE_W      = 6;
  localparam int unsigned MODE_XOR    = 0;
  localparam int unsigned MODE_RSHIFT = 1;
  localparam int unsigned MODE_LSHIFT = 2;
  localparam int unsigned MODE_ECAE   = 3;
  localparam int unsigned MODE_DCAE   = 4;
  localparam int unsigned MODE_MUL    = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } pms_state_t;

  // True when exactly one bit of the mode request is set.
  function automatic logic is_onehot(input logic [MODE_W-1:0] v);
    return (v != '0) && ((v & (v - MODE_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/pms_debounce.sv
// Per-bit 2-flop synchronizer with an optional stability filter (PMS_DEBOUNCE_EN).
module pms_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

`ifdef PMS_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             clean_q;

  // Accept a new level only after it has differed from the held value long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else if (sync_q2 == clean_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_q   <= '0;
      clean_q <= sync_q2;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign clean = clean_q;
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  assign clean = sync_q2;
`endif

endmodule

// File: rtl/proc_mode_sequencer.sv
// Sequences processor reset release and a one-hot mode strobe from raw board inputs.
// Optional input debounce is enabled with the PMS_DEBOUNCE_EN macro.
module proc_mode_sequencer
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES    = 1,
  parameter int unsigned SETTLE_CYCLES   = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [MODE_W-1:0] sel,
  input  logic              start,
  input  logic              proc_done,
  output logic              proc_reset,
  output logic              mode_xor,
  output logic              mode_rshift,
  output logic              mode_lshift,
  output logic              mode_ecae,
  output logic              mode_dcae,
  output logic              mode_mul,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CNT_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned IN_W    = MODE_W + 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [IN_W-1:0]   raw_in;
  logic [IN_W-1:0]   cond_in;
  logic [MODE_W-1:0] sel_cond;
  logic              start_cond;
  logic              start_q;
  logic              start_pulse;

  assign raw_in = {start, sel};

  for (genvar i = 0; i < IN_W; i++) begin : g_cond
    pms_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_in[i]),
      .clean(cond_in[i])
    );
  end

  assign sel_cond   = cond_in[MODE_W-1:0];
  assign start_cond = cond_in[MODE_W];

  always_ff @(posedge clk) begin
    if (reset) start_q <= 1'b0;
    else       start_q <= start_cond;
  end

  assign start_pulse = start_cond & ~start_q;

  pms_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MODE_W-1:0] sel_q, sel_d;
  logic              err_q, err_d;
  logic              proc_reset_q, proc_reset_d;
  logic              busy_q, busy_d;
  logic [MODE_W-1:0] mode_q, mode_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      err_q        <= 1'b0;
      proc_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      mode_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      err_q        <= err_d;
      proc_reset_q <= proc_reset_d;
      busy_q       <= busy_d;
      mode_q       <= mode_d;
    end
  end

  // Next state, counter and Moore outputs decoded from the next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    sel_d        = sel_q;
    err_d        = err_q;
    proc_reset_d = 1'b1;
    busy_d       = 1'b0;
    mode_d       = '0;

    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          if (is_onehot(sel_cond)) begin
            sel_d   = sel_cond;
            err_d   = 1'b0;
            state_d = HOLD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = SETTLE;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = RUN;
        else                      cnt_d   = cnt_q + CNT_W'(1);
      end
      RUN: begin
        if (proc_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    proc_reset_d = (state_d == IDLE) || (state_d == HOLD);
    busy_d       = (state_d != IDLE);
    mode_d       = (state_d == RUN) ? sel_d : '0;
  end

  assign proc_reset  = proc_reset_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign mode_xor    = mode_q[MODE_XOR];
  assign mode_rshift = mode_q[MODE_RSHIFT];
  assign mode_lshift = mode_q[MODE_LSHIFT];
  assign mode_ecae   = mode_q[MODE_ECAE];
  assign mode_dcae   = mode_q[MODE_DCAE];
  assign mode_mul    = mode_q[MODE_MUL];

endmodule

// File: doc/proc_mode_sequencer.md
# proc_mode_sequencer

Board-side driver for the vector processor's control inputs: takes a raw 6-bit mode selection and a start button, and produces the processor reset and one-hot mode strobes. Cycle timing matches the simulation bench: processor reset held, then released, then exactly one mode line raised. Sits between the FPGA I/O pins and the `processor` top and replaces the bench stimulus in hardware builds.

## Interface
- `RESET_CYCLES`, 1: cycles `proc_reset` is held after a valid start (≥1).
- `SETTLE_CYCLES`, 1: cycles with reset released and all modes low before the mode line rises (≥1).
- `DEBOUNCE_CYCLES`, 16: cycles an input must be stable to be accepted (only with `PMS_DEBOUNCE_EN`).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  6  raw mode request, bit order [5:0] = {mul, dcae, ecae, lshift, rshift, xor}; asynchronous to `clk`.
- `start`  in  1  raw start button, active-high, asynchronous.
- `proc_done`  in  1  processor completion pulse, synchronous to `clk`.
- `proc_reset`  out  1  drives processor `reset`.
- `mode_xor`, `mode_rshift`, `mode_lshift`, `mode_ecae`, `mode_dcae`, `mode_mul`  out  1 each  one-hot mode strobes.
- `busy`  out  1  high in HOLD, SETTLE, RUN.
- `err`  out  1  sticky invalid-selection flag.

## Operation
- Input conditioning: `sel` and `start` pass through 2-flop synchronizers. A start event is a rising edge of the conditioned `start` (single-cycle internal pulse).
- FSM states: IDLE, HOLD, SETTLE, RUN.
- IDLE: `proc_reset`=1, all modes 0, `busy`=0. On a start event:
  - conditioned `sel` is exactly one-hot → latch `sel`, clear `err`, go to HOLD.
  - `sel` is zero or multi-hot → set `err`, stay in IDLE.
- HOLD: `proc_reset`=1, modes 0. Stays RESET_CYCLES cycles, then goes to SETTLE.
- SETTLE: `proc_reset`=0, modes 0. Stays SETTLE_CYCLES cycles, then goes to RUN.
- RUN: `proc_reset`=0. The one mode output matching the latched `sel` is 1 and all others are 0. `proc_done`=1 → IDLE.
- Start events outside IDLE are ignored. Changes to `sel` outside IDLE are ignored, because the latched copy is used.
- `proc_done` outside RUN is ignored.
- Outputs are registered (Moore) and decoded from the next state, so they change on the same edge as the state.
- Reset values: state IDLE, `proc_reset`=1, all modes 0, `busy`=0, `err`=0, counters 0, latched sel 0. Asserting `reset` mid-RUN drops the mode line and raises `proc_reset` on the next edge.
- Counter width is $clog2(max(RESET_CYCLES, SETTLE_CYCLES)+1). The counter clears on every state entry.

## Timing
- Let edge E be the edge at which the FSM samples the start pulse in IDLE.
- HOLD occupies RESET_CYCLES cycles starting at E.
- SETTLE occupies SETTLE_CYCLES cycles after HOLD.
- The mode line rises at edge E+RESET_CYCLES+SETTLE_CYCLES.
- `start` pin to start pulse: 3 edges (2 sync + edge detect). With `PMS_DEBOUNCE_EN`, add DEBOUNCE_CYCLES.
- RUN → IDLE: the mode line falls and `proc_reset` rises on the edge that samples `proc_done`=1.
- A start event and `proc_done` in the same cycle while in RUN: `proc_done` wins and the start event is lost.

## Configuration
- `PMS_DEBOUNCE_EN` defined: each synchronized input (`start` and every `sel` bit) goes through a stability counter. A bit updates its conditioned value only after DEBOUNCE_CYCLES consecutive equal samples.
- `PMS_DEBOUNCE_EN` undefined: the synchronizer output is used directly and `DEBOUNCE_CYCLES` is unused.

## Structure
- Shared package `proc_ctrl_pkg`:
  - state enum `pms_state_t` {IDLE, HOLD, SETTLE, RUN};
  - mode bit index constants `MODE_XOR`=0 … `MODE_MUL`=5;
  - `MODE_W`=6.
- One sub-module, `pms_debounce`: a per-bit synchronizer plus an optional stability counter, instantiated 7 times.

## Test plan
- Start with `sel`=6'b000010, defaults, debounce off → `proc_reset`=1 through HOLD, 0 for 1 cycle with modes 0, then `mode_rshift`=1 and the other modes 0; `busy`=1 throughout.
- Start with `sel`=6'b000011, then with `sel`=0 → `err`=1 and the FSM stays in IDLE with `proc_reset`=1. A later start with `sel`=6'b100000 → `err`=0 and `mode_mul`=1.
- In RUN with xor, change `sel` to 6'b001000 and pulse `start` → `mode_xor` stays 1. `proc_done` pulse → modes 0 and `proc_reset`=1 on the next edge.
- `RESET_CYCLES`=3, `SETTLE_CYCLES`=2 → `proc_reset` high for exactly 3 cycles after E, and the mode line rises at E+5.
- Assert `reset` for 1 cycle in RUN → all modes 0, `proc_reset`=1, `busy`=0 on the next edge.
- `PMS_DEBOUNCE_EN`, `DEBOUNCE_CYCLES`=4, `start` glitch of 2 cycles → no start event. `start` held for 10 cycles → exactly one start event.
